uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit shift register: the read side of the UART TX FIFO. It captures one byte per FIFO dequeue pulse and serialises it onto the `tx` line as start bit, LSB-first data, optional parity, and stop bit(s). It holds `tx_busy` high for the whole frame so that the FIFO dequeues exactly one entry per frame.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLKS_PER_BIT`, 868: `clk` cycles per bit (100 MHz / 115200). Must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_WIDTH  byte to send; connects to FIFO `buff_out`.
- `tx_valid`  in  1  capture strobe; connects to FIFO `data_valid`.
- `tx_busy`  out  1  frame in progress; connects to FIFO `tx_busy`.
- `tx`  out  1  serial line, idles high.
- `tx_done`  out  1  one-cycle pulse when a frame's last stop bit ends.

## Operation
- State machine:
  - IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - PARITY is skipped when `PARITY_EN` = 0.
- IDLE:
  - `tx` = 1, `tx_busy` = 0.
  - On `tx_valid` = 1 at a rising edge: latch `tx_data` into the shift register, compute parity from the latched byte, clear the baud and bit counters, and go to START.
- START: `tx` = 0 for `CLKS_PER_BIT` cycles.
- DATA:
  - `tx` = shift register bit 0.
  - Shift right every `CLKS_PER_BIT` cycles.
  - Bit counter runs 0..DATA_WIDTH-1; leave after bit DATA_WIDTH-1.
- PARITY:
  - Even: `tx` = XOR of all data bits.
  - Odd: `tx` = inverse of that XOR.
  - Lasts one bit time.
- STOP:
  - `tx` = 1 for `STOP_BITS` × `CLKS_PER_BIT` cycles.
  - On the final cycle, pulse `tx_done` and return to IDLE.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..CLKS_PER_BIT-1; the terminal count advances the bit.
  - No free-running drift: the counter restarts at 0 on every capture.
- `tx_busy` = (state != IDLE), registered.
- `tx` is a registered output with no combinational glitches.
- `tx_valid` outside IDLE is ignored. The FIFO never asserts it then; the bench checks this.
- Reset (asynchronous, any time, including mid-frame):
  - State → IDLE.
  - `tx` = 1, `tx_busy` = 0, `tx_done` = 0, counters and shift register cleared.
  - A partially sent frame is abandoned, never resumed.

## Timing
- Capture: `tx_valid` high at edge N. From edge N onward, `tx` = 0 and `tx_busy` = 1.
- `tx_busy` must be high in the cycle after the capture edge. The FIFO computes `data_valid = !tx_busy && !empty` and pops on the same edge, so this guarantees exactly one pop per frame.
- Frame length: F = (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles of `tx_busy` = 1.
- `tx_done` is high in the last cycle of STOP. `tx_busy` falls at the next edge.
- Back-to-back frames (FIFO non-empty):
  - Exactly one idle cycle (`tx` = 1, `tx_busy` = 0) between frames.
  - Frame period is F + 1 cycles.
- Latency from capture to the first data bit on `tx`: CLKS_PER_BIT cycles after the capture edge.

## Test plan
- Reset:
  - Assert `rst_n` = 0 with `tx_valid` toggling.
  - Required: `tx` = 1, `tx_busy` = 0, `tx_done` = 0 throughout. No capture occurs.
- Single frame, `CLKS_PER_BIT` = 4, no parity, 1 stop bit, byte 0xA5:
  - Required `tx` sequence in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_busy` high for exactly 40 cycles.
  - One `tx_done` pulse in cycle 40.
- Parity:
  - `PARITY_EN` = 1, even parity, byte 0x07 → parity bit 1.
  - `PARITY_ODD` = 1, byte 0x07 → parity bit 0.
  - `STOP_BITS` = 2 → busy for 48 cycles at `CLKS_PER_BIT` = 4.
- Integration with the TX FIFO:
  - LSU writes 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: three frames in that order, each 41 cycles apart, and FIFO `empty` after the third capture.
  - Exactly 3 `data_valid` pulses.
- Mid-frame reset:
  - Assert `rst_n` during bit 3 of 0xFF.
  - Required: `tx` goes to 1 immediately and `tx_busy` to 0.
  - After release with `tx_valid` = 0: no further activity and no `tx_done`.
- Stray strobe:
  - Force `tx_valid` = 1 mid-frame with 0x00.
  - Required: the current frame completes unchanged and 0x00 is not captured.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit shift register fed by the TX FIFO
// Serialises one captured word per frame: start, LSB-first data, optional parity, stop bit(s).
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_busy,
  output logic                  tx,
  output logic                  tx_done
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int BIT_W   = (BIT_MAX > 2) ? $clog2(BIT_MAX) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_next;
  logic [BAUD_W-1:0]     baud_cnt, baud_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_bit, parity_next;
  logic                  tx_next, busy_next, done_next;
  logic                  baud_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_bit <= parity_next;
      tx         <= tx_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_bit;
    baud_done   = (baud_cnt == BAUD_LAST);

    if (state != S_IDLE) begin
      baud_next = baud_done ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      S_IDLE: begin
        // Capture restarts the baud counter so every frame is aligned to its strobe.
        if (tx_valid) begin
          shift_next  = tx_data;
          parity_next = (^tx_data) ^ (PARITY_ODD != 0);
          baud_next   = '0;
          bit_next    = '0;
          state_next  = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          bit_next   = '0;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          bit_next   = '0;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          if (bit_cnt == STOP_LAST) begin
            bit_next   = '0;
            state_next = S_IDLE;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are decoded from next-state values so the registered line changes on the bit edge.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = parity_next;
      default:  tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_STOP) && (baud_next == BAUD_LAST) && (bit_next == STOP_LAST);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx
// Three instances cover no-parity, even-parity and odd-parity/two-stop frames at 4 clocks per bit.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct packed {
    logic [15:0] bits;
    int          nbits;
    bit          abort;
    int          period;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic [2:0] tx_w, busy_w, done_w;
  logic [7:0] man_d0;
  logic       man_v0;
  logic       fifo_mode;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int last_start [3];
  exp_t q0[$], q1[$], q2[$];

  // TX FIFO model: data_valid = !tx_busy && !empty, pop on the same edge.
  logic [7:0] fifo_mem [0:7];
  logic [2:0] wr_ptr = '0, rd_ptr = '0;
  logic [3:0] fifo_cnt = '0;
  logic       lsu_we;
  logic [7:0] lsu_wdata;
  logic       data_valid;
  int         dv_pulses = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign data_valid = fifo_mode && !busy_w[0] && (fifo_cnt != 4'd0);
  assign v0 = fifo_mode ? data_valid : man_v0;
  assign d0 = fifo_mode ? fifo_mem[rd_ptr] : man_d0;

  always @(posedge clk) begin
    if (lsu_we) begin
      fifo_mem[wr_ptr] <= lsu_wdata;
      wr_ptr <= wr_ptr + 3'd1;
    end
    if (data_valid) begin
      rd_ptr    <= rd_ptr + 3'd1;
      dv_pulses <= dv_pulses + 1;
    end
    fifo_cnt <= fifo_cnt + 4'(lsu_we) - 4'(data_valid);
  end

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_valid(v0),
    .tx_busy(busy_w[0]), .tx(tx_w[0]), .tx_done(done_w[0]));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
    .tx_busy(busy_w[1]), .tx(tx_w[1]), .tx_done(done_w[1]));
  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
    .tx_busy(busy_w[2]), .tx(tx_w[2]), .tx_done(done_w[2]));

  function automatic void check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endfunction

  function automatic void push_exp(input int k, input logic [15:0] bits, input int nbits,
                                   input bit abort, input int period);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.abort = abort; e.period = period;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Decodes each busy window of instance k and scores it against the next expected frame.
  task automatic monitor(input int k);
    int          cyc, dones, done_at, glitches, start;
    logic [15:0] bits, mask;
    logic        cur;
    bit          ok, aborted;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n && busy_w[k]) begin
        cyc = 0; bits = '0; dones = 0; done_at = -1; glitches = 0;
        start = cyc_cnt; cur = tx_w[k];
        while (rst_n && busy_w[k] && cyc < 100) begin
          if (cyc % CPB == 0) cur = tx_w[k];
          else if (tx_w[k] !== cur) glitches++;
          if ((cyc % CPB == CPB / 2) && (cyc / CPB < 16)) bits[cyc / CPB] = tx_w[k];
          if (done_w[k]) begin dones++; done_at = cyc; end
          cyc++;
          @(negedge clk);
        end
        aborted = !rst_n;
        pop_exp(k, e, ok);
        if (!ok) begin
          check($sformatf("unexpected_frame%0d", k), cyc, 0);
        end else begin
          check($sformatf("abort%0d", k), int'(aborted), int'(e.abort));
          if (!e.abort && !aborted) begin
            mask = 16'((32'd1 << e.nbits) - 1);
            check($sformatf("frame_bits%0d", k), int'(bits & mask), int'(e.bits));
            check($sformatf("busy_len%0d", k), cyc, e.nbits * CPB);
            check($sformatf("done_count%0d", k), dones, 1);
            check($sformatf("done_pos%0d", k), done_at, e.nbits * CPB - 1);
            check($sformatf("glitch%0d", k), glitches, 0);
            check($sformatf("idle_line%0d", k), int'(tx_w[k]), 1);
            if (e.period != 0) check($sformatf("period%0d", k), start - last_start[k], e.period);
          end
        end
        last_start[k] = start;
      end
    end
  endtask

  task automatic drive(input int k, input logic [7:0] b, input logic v);
    case (k)
      0: begin man_d0 = b; man_v0 = v; end
      1: begin d1 = b; v1 = v; end
      default: begin d2 = b; v2 = v; end
    endcase
  endtask

  task automatic send(input int k, input logic [7:0] b);
    int n = 0;
    while (busy_w[k] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check($sformatf("send_timeout%0d", k), n, 0);
    drive(k, b, 1'b1);
    @(negedge clk);
    drive(k, 8'h00, 1'b0);
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while ((busy_w[k] || q_size(k) != 0) && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) check($sformatf("done_timeout%0d", k), n, 0);
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    int n, busy_seen, done_seen;
    rst_n = 1'b0; fifo_mode = 1'b0; lsu_we = 1'b0; lsu_wdata = 8'h00;
    man_d0 = 8'h00; man_v0 = 1'b0; d1 = 8'h00; v1 = 1'b0; d2 = 8'h00; v2 = 1'b0;

    // Reset held with strobes toggling: outputs stay idle, nothing captured.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive(0, 8'hFF, i[0]); drive(1, 8'hFF, ~i[0]); drive(2, 8'hFF, i[0]);
      @(negedge clk);
      check("rst_tx", int'(tx_w), 7);
      check("rst_busy", int'(busy_w), 0);
      check("rst_done", int'(done_w), 0);
    end
    drive(0, 8'h00, 1'b0); drive(1, 8'h00, 1'b0); drive(2, 8'h00, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", int'(busy_w), 0);
    check("post_rst_tx", int'(tx_w), 7);

    // Single frames: 0xA5 plain; 0x07/0x00 even parity; 0x07/0xFF odd parity with 2 stops.
    push_exp(0, 16'h034A, 10, 1'b0, 0); send(0, 8'hA5);
    push_exp(1, 16'h060E, 11, 1'b0, 0); send(1, 8'h07);
    push_exp(2, 16'h0C0E, 12, 1'b0, 0); send(2, 8'h07);
    push_exp(1, 16'h0400, 11, 1'b0, 0); send(1, 8'h00);
    push_exp(2, 16'h0FFE, 12, 1'b0, 0); send(2, 8'hFF);
    wait_done(0); wait_done(1); wait_done(2);

    // FIFO integration: three consecutive writes drain back-to-back, 41 cycles apart.
    push_exp(0, 16'h0222, 10, 1'b0, 0);
    push_exp(0, 16'h0244, 10, 1'b0, 41);
    push_exp(0, 16'h0266, 10, 1'b0, 41);
    @(negedge clk);
    fifo_mode = 1'b1;
    lsu_we = 1'b1; lsu_wdata = 8'h11; @(negedge clk);
    lsu_wdata = 8'h22; @(negedge clk);
    lsu_wdata = 8'h33; @(negedge clk);
    lsu_we = 1'b0;
    n = 0;
    while (dv_pulses < 3 && n < 300) begin @(negedge clk); n++; end
    check("fifo_third_pop_seen", int'(dv_pulses >= 3), 1);
    check("fifo_empty", int'(fifo_cnt), 0);
    wait_done(0);
    repeat (5) @(negedge clk);
    check("dv_pulses", dv_pulses, 3);
    fifo_mode = 1'b0;

    // Mid-frame reset during data bit 3 of 0xFF.
    push_exp(0, 16'h0000, 0, 1'b1, 0);
    send(0, 8'hFF);
    repeat (17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", int'(tx_w[0]), 1);
    check("mid_rst_busy", int'(busy_w[0]), 0);
    check("mid_rst_done", int'(done_w[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0; done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      busy_seen += int'(busy_w[0]);
      done_seen += int'(done_w[0]);
    end
    check("after_rst_busy", busy_seen, 0);
    check("after_rst_done", done_seen, 0);

    // Stray strobe with 0x00 mid-frame must not disturb 0xA5.
    push_exp(0, 16'h034A, 10, 1'b0, 0);
    send(0, 8'hA5);
    repeat (10) @(negedge clk);
    drive(0, 8'h00, 1'b1);
    repeat (8) @(negedge clk);
    drive(0, 8'h00, 1'b0);
    wait_done(0);
    repeat (20) @(negedge clk);
    check("queues_drained", q_size(0) + q_size(1) + q_size(2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
